// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types and defaults for the PWM period controller
package pwm_ctrl_pkg;

  localparam int DIV_W        = 8;
  localparam int DEFAULT_TC   = 63;
  localparam int DEFAULT_DUTY = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIV_W-1:0] tc;
    logic [DIV_W-1:0] duty;
  } cfg_t;

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - period counter with wrap detect and registered TICK/PWM compare
module pwm_period_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] tc_act,
  input  logic [DIV_W-1:0] duty_next,
  output logic             wrap,
  output logic             tick,
  output logic             pwm_out
);

  logic             run_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  // The first running cycle after enable holds cnt at 0 so TICK lands on it.
  always_comb begin
    wrap    = run_q && (cnt == tc_act);
    cnt_nxt = '0;
    if (enable && run_q && !wrap)
      cnt_nxt = cnt + DIV_W'(1);
  end

  // Outputs are computed from next-cycle values so they align with the registered cnt;
  // duty_next lets a new period's first cycle use the freshly committed duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt     <= '0;
      tick    <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      run_q   <= enable;
      cnt     <= cnt_nxt;
      tick    <= enable && (cnt_nxt == '0);
      pwm_out <= enable && (cnt_nxt < duty_next);
    end
  end

endmodule

// File: rtl/pwm_period_controller.sv
// rtl/pwm_period_controller.sv - runtime-configurable PWM period/duty scheduler with boundary-only updates
module pwm_period_controller #(
  parameter int DIV_W        = pwm_ctrl_pkg::DIV_W,
  parameter int DEFAULT_TC   = pwm_ctrl_pkg::DEFAULT_TC,
  parameter int DEFAULT_DUTY = pwm_ctrl_pkg::DEFAULT_DUTY
) (
  input  logic             CLK_50M,
  input  logic             RST,
  input  logic             EN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [DIV_W-1:0] CFG_TC,
  input  logic [DIV_W-1:0] CFG_DUTY,
  output logic             TICK,
  output logic             PWM_OUT,
  output logic             RUNNING
);

  import pwm_ctrl_pkg::*;

  state_e           state;
  state_e           state_nxt;
  logic [DIV_W-1:0] tc_act;
  logic [DIV_W-1:0] duty_act;
  logic [DIV_W-1:0] tc_nxt;
  logic [DIV_W-1:0] duty_nxt;
  logic [DIV_W-1:0] tc_pend;
  logic [DIV_W-1:0] duty_pend;
  logic             accept;
  logic             load_pend;
  logic             run_nxt;
  logic             wrap;

  assign accept  = CFG_VALID && CFG_READY;
  assign run_nxt = (state_nxt != IDLE);

  always_comb begin
    state_nxt = state;
    tc_nxt    = tc_act;
    duty_nxt  = duty_act;
    load_pend = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tc_nxt   = CFG_TC;
          duty_nxt = CFG_DUTY;
        end
        if (EN)
          state_nxt = RUN;
      end
      RUN: begin
        // Stopping commits directly; otherwise the request waits for a wrap seen from PEND,
        // so an accept on the wrap cycle costs exactly one more old-length period.
        if (!EN) begin
          state_nxt = IDLE;
          if (accept) begin
            tc_nxt   = CFG_TC;
            duty_nxt = CFG_DUTY;
          end
        end else if (accept) begin
          load_pend = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!EN || wrap) begin
          state_nxt = EN ? RUN : IDLE;
          tc_nxt    = tc_pend;
          duty_nxt  = duty_pend;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      tc_act    <= DIV_W'(DEFAULT_TC);
      duty_act  <= DIV_W'(DEFAULT_DUTY);
      tc_pend   <= DIV_W'(DEFAULT_TC);
      duty_pend <= DIV_W'(DEFAULT_DUTY);
      RUNNING   <= 1'b0;
      CFG_READY <= 1'b1;
    end else begin
      state     <= state_nxt;
      tc_act    <= tc_nxt;
      duty_act  <= duty_nxt;
      if (load_pend) begin
        tc_pend   <= CFG_TC;
        duty_pend <= CFG_DUTY;
      end
      RUNNING   <= run_nxt;
      CFG_READY <= (state_nxt != PEND);
    end
  end

  pwm_period_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk      (CLK_50M),
    .rst      (RST),
    .enable   (run_nxt),
    .tc_act   (tc_act),
    .duty_next(duty_nxt),
    .wrap     (wrap),
    .tick     (TICK),
    .pwm_out  (PWM_OUT)
  );

endmodule

// File: tb/tb_pwm_period_controller.sv
// tb/tb_pwm_period_controller.sv - directed self-checking bench for pwm_period_controller
module tb_pwm_period_controller;
  import pwm_ctrl_pkg::*;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_tc;
  logic [DIV_W-1:0] cfg_duty;
  logic             tick;
  logic             pwm_out;
  logic             running;
  logic [3:0]       obs;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_period_controller dut (
    .CLK_50M  (clk),
    .RST      (rst),
    .EN       (en),
    .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready),
    .CFG_TC   (cfg_tc),
    .CFG_DUTY (cfg_duty),
    .TICK     (tick),
    .PWM_OUT  (pwm_out),
    .RUNNING  (running)
  );

  assign obs = {tick, pwm_out, running, cfg_ready};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed {tick,pwm,run,ready}=%b required %b", tag, observed, expected);
    end
  endtask

  // Advances n cycles; cycle i is expected at count (c0+i) mod (tc+1).
  task automatic run_check(input string tag, input int n, input int tc, input int duty,
                           input int c0, input logic rdy);
    for (int i = 0; i < n; i++) begin
      int c;
      step();
      c = (c0 + i) % (tc + 1);
      check($sformatf("%s[%0d]", tag, i), obs, {(c == 0), (c < duty), 1'b1, rdy});
    end
  endtask

  task automatic offer(input cfg_t c);
    cfg_valid = 1'b1;
    cfg_tc    = c.tc;
    cfg_duty  = c.duty;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_tc = '0; cfg_duty = '0;
    step(); step();
    check("reset", obs, 4'b0001);
    rst = 1'b0;
    step();
    check("idle_after_reset", obs, 4'b0001);

    // defaults: 64-cycle period, 32 high
    en = 1'b1;
    run_check("default", 128, 63, 32, 0, 1'b1);
    en = 1'b0; step();
    check("stop1", obs, 4'b0001);

    // configure in IDLE
    offer('{tc: 8'd9, duty: 8'd3}); step();
    check("idle_cfg9", obs, 4'b0001);
    cfg_valid = 1'b0; en = 1'b1;
    run_check("tc9", 30, 9, 3, 0, 1'b1);
    en = 1'b0; step();
    check("stop2", obs, 4'b0001);

    // mid-period request at cnt=20; a held VALID during PEND must be ignored
    offer('{tc: 8'd63, duty: 8'd32}); step();
    check("idle_cfg63", obs, 4'b0001);
    cfg_valid = 1'b0; en = 1'b1;
    run_check("pre", 21, 63, 32, 0, 1'b1);
    offer('{tc: 8'd15, duty: 8'd8});
    run_check("pend", 1, 63, 32, 21, 1'b0);
    offer('{tc: 8'd5, duty: 8'd1});
    run_check("pend_hold", 41, 63, 32, 22, 1'b0);
    cfg_valid = 1'b0;
    run_check("pend_last", 1, 63, 32, 63, 1'b0);
    run_check("tc15", 32, 15, 8, 0, 1'b1);

    // accept on the wrap cycle: one more old-length period
    offer('{tc: 8'd4, duty: 8'd2});
    run_check("wrap_acc", 1, 15, 8, 0, 1'b0);
    cfg_valid = 1'b0;
    run_check("old_period", 15, 15, 8, 1, 1'b0);
    run_check("tc4", 10, 4, 2, 0, 1'b1);

    // boundaries: TC=0, DUTY=0, DUTY>TC
    en = 1'b0; step();
    check("stop3", obs, 4'b0001);
    offer('{tc: 8'd0, duty: 8'd1}); step();
    check("idle_cfg0", obs, 4'b0001);
    cfg_valid = 1'b0; en = 1'b1;
    run_check("tc0", 5, 0, 1, 0, 1'b1);
    offer('{tc: 8'd9, duty: 8'd0});
    run_check("tc0_pend", 1, 0, 1, 0, 1'b0);
    cfg_valid = 1'b0;
    run_check("duty0", 20, 9, 0, 0, 1'b1);
    offer('{tc: 8'd9, duty: 8'd200});
    run_check("d200_wrap", 1, 9, 0, 0, 1'b0);
    cfg_valid = 1'b0;
    run_check("d200_old", 9, 9, 0, 1, 1'b0);
    run_check("duty200", 20, 9, 200, 0, 1'b1);

    // EN dropped in PEND commits the pending config
    offer('{tc: 8'd6, duty: 8'd4});
    run_check("p6", 1, 9, 200, 0, 1'b0);
    cfg_valid = 1'b0;
    run_check("p6b", 3, 9, 200, 1, 1'b0);
    en = 1'b0; step();
    check("drop_pend", obs, 4'b0001);
    step();
    check("idle_hold", obs, 4'b0001);
    en = 1'b1;
    run_check("tc6", 14, 6, 4, 0, 1'b1);

    // asynchronous reset mid-PEND discards the pending config
    offer('{tc: 8'd2, duty: 8'd1});
    run_check("p2", 1, 6, 4, 0, 1'b0);
    cfg_valid = 1'b0;
    run_check("p2b", 2, 6, 4, 1, 1'b0);
    #5 rst = 1'b1;
    #1 check("async_rst", obs, 4'b0001);
    step();
    check("rst_hold", obs, 4'b0001);
    rst = 1'b0;
    run_check("defaults", 70, 63, 32, 0, 1'b1);
    en = 1'b0; step();
    check("final_stop", obs, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
